// File: rtl/fifo.sv
// Generic synchronous FIFO: registered read data appears the cycle after read_enable.
// Writes while full and reads while empty are ignored; full/empty are flop-derived.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             write_enable,
    input  logic [WIDTH-1:0] write_data,
    output logic             full,
    input  logic             read_enable,
    output logic [WIDTH-1:0] read_data,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] read_data_q;
    logic             do_write;
    logic             do_read;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign do_write  = write_enable & ~full;
    assign do_read   = read_enable & ~empty;
    assign read_data = read_data_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_write) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_read)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_write, do_read})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_write) mem_q[wr_ptr_q] <= write_data;
        if (do_read)  read_data_q     <= mem_q[rd_ptr_q];
    end
endmodule

// File: rtl/fifo_read_valid_ready_adapter.sv
// Drains a read_enable/empty FIFO into a valid-ready source; first word valid 2 cycles after issue.
// Backpressure holds a 2-entry buffer; new reads issue only when buffered + in-flight words stay <= 2.
module fifo_read_valid_ready_adapter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    output logic             fifo_read_enable,
    input  logic [WIDTH-1:0] fifo_read_data,
    input  logic             fifo_empty,
    output logic [WIDTH-1:0] read_data,
    output logic             read_valid,
    input  logic             read_ready,
    output logic             idle
);
    localparam int BUFFER_DEPTH = 2;

    logic [WIDTH-1:0] storage_q [BUFFER_DEPTH];
    logic [1:0]       occupancy_q;
    logic [1:0]       occupancy_d;
    logic             inflight_q;
    logic             head_q;
    logic             tail_q;
    logic             pop;

    assign pop = read_valid & read_ready;

    // Words already owned by the buffer after this edge; the in-flight word must always have a slot.
    assign occupancy_d = occupancy_q + {1'b0, inflight_q} - {1'b0, pop};

    assign fifo_read_enable = ~reset & ~fifo_empty & (occupancy_d < 2'd2);

    assign read_valid = (occupancy_q != 2'd0);
    assign read_data  = storage_q[head_q];
    assign idle       = ~read_valid & ~inflight_q & fifo_empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            occupancy_q <= 2'd0;
            inflight_q  <= 1'b0;
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
        end else begin
            occupancy_q <= occupancy_d;
            inflight_q  <= fifo_read_enable;
            if (inflight_q) tail_q <= ~tail_q;
            if (pop)        head_q <= ~head_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && inflight_q) storage_q[tail_q] <= fifo_read_data;
    end

    occupancy_bound: assert property (@(posedge clock) disable iff (reset) occupancy_q <= 2'd2);
endmodule

// File: tb/tb_fifo_read_valid_ready_adapter.sv
// Upstream fifo + adapter loop; a queue of pushed words is the ordering model, checked on every transfer.
module tb_fifo_read_valid_ready_adapter;
    logic       clock = 1'b0;
    logic       reset;
    logic       push_en;
    logic [7:0] push_dat;
    logic       up_full;
    logic       up_empty;
    logic       fifo_read_enable;
    logic [7:0] fifo_read_data;
    logic [7:0] read_data;
    logic       read_valid;
    logic       read_ready;
    logic       idle;

    always #5 clock = ~clock;

    fifo #(.WIDTH(8), .DEPTH(32)) u_up (
        .clock       (clock),
        .reset       (reset),
        .write_enable(push_en),
        .write_data  (push_dat),
        .full        (up_full),
        .read_enable (fifo_read_enable),
        .read_data   (fifo_read_data),
        .empty       (up_empty)
    );

    fifo_read_valid_ready_adapter #(.WIDTH(8)) dut (
        .clock           (clock),
        .reset           (reset),
        .fifo_read_enable(fifo_read_enable),
        .fifo_read_data  (fifo_read_data),
        .fifo_empty      (up_empty),
        .read_data       (read_data),
        .read_valid      (read_valid),
        .read_ready      (read_ready),
        .idle            (idle)
    );

    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] exp_q[$];
    int         cyc = 0;
    int         en_count = 0;
    int         vld_count = 0;
    int         last_en_cyc = 0;
    int         last_vld_cyc = 0;
    int         outstanding = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: ordering, stall stability and the issue rules, sampled mid-cycle.
    always @(negedge clock) begin
        if (reset) begin
            outstanding = 0;
            stall_prev  = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid_held", {31'd0, read_valid}, 32'd1);
                chk("stall_data_held", {24'd0, read_data}, {24'd0, stall_data});
            end
            if (fifo_read_enable) begin
                en_count++;
                outstanding++;
                last_en_cyc = cyc;
                chk("issue_while_empty", {31'd0, up_empty}, 32'd0);
            end
            if (read_valid) begin
                vld_count++;
                last_vld_cyc = cyc;
            end
            if (read_valid && read_ready) begin
                outstanding--;
                if (exp_q.size() == 0) chk("spurious_word", {24'd0, read_data}, 32'hFFFF_FFFF);
                else chk("order", {24'd0, read_data}, {24'd0, exp_q.pop_front()});
            end
            chk("outstanding_le_2", {31'd0, (outstanding <= 2)}, 32'd1);
            stall_prev = read_valid & ~read_ready;
            stall_data = read_data;
        end
        cyc++;
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        if (!up_full) begin
            push_en  = 1'b1;
            push_dat = d;
            exp_q.push_back(d);
        end
        cycle();
        push_en = 1'b0;
    endtask

    task automatic drain(input string name, input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            cycle();
            n++;
        end
        repeat (3) cycle();
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        int e0, v0, n, pushed;
        reset      = 1'b1;
        push_en    = 1'b0;
        push_dat   = 8'h00;
        read_ready = 1'b0;
        repeat (3) cycle();
        @(negedge clock);
        chk("reset_read_valid", {31'd0, read_valid}, 32'd0);
        chk("reset_read_enable", {31'd0, fifo_read_enable}, 32'd0);
        chk("reset_idle", {31'd0, idle}, 32'd1);
        cycle();
        reset = 1'b0;
        cycle();

        // Single word latency
        read_ready = 1'b1;
        e0 = en_count;
        v0 = vld_count;
        push(8'hA5);
        repeat (8) cycle();
        chk("single_enable_pulses", en_count - e0, 1);
        chk("single_valid_cycles", vld_count - v0, 1);
        chk("single_latency", last_vld_cyc - last_en_cyc, 2);
        chk("single_idle_after", {31'd0, idle}, 32'd1);

        // Streaming
        read_ready = 1'b0;
        for (int i = 1; i <= 16; i++) push(8'(i));
        repeat (5) cycle();
        read_ready = 1'b1;
        n = 0;
        repeat (16) begin
            @(negedge clock);
            if (read_valid) n++;
        end
        chk("stream_no_bubble", n, 16);
        drain("stream_drain", 50);

        // Backpressure
        read_ready = 1'b0;
        e0 = en_count;
        for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
        repeat (6) cycle();
        @(negedge clock);
        chk("bp_enable_pulses", en_count - e0, 2);
        chk("bp_valid", {31'd0, read_valid}, 32'd1);
        chk("bp_head_data", {24'd0, read_data}, 32'h20);
        cycle();
        read_ready = 1'b1;
        drain("bp_drain", 50);

        // Random stall
        pushed = 0;
        n = 0;
        while (pushed < 1000 && n < 20000) begin
            read_ready = 1'($urandom_range(0, 1));
            if (!up_full && $urandom_range(0, 1) == 1) begin
                push_en  = 1'b1;
                push_dat = 8'($urandom);
                exp_q.push_back(push_dat);
                pushed++;
            end
            cycle();
            push_en = 1'b0;
            n++;
        end
        chk("random_all_pushed", pushed, 1000);
        n = 0;
        while (exp_q.size() != 0 && n < 10000) begin
            read_ready = 1'($urandom_range(0, 1));
            cycle();
            n++;
        end
        read_ready = 1'b1;
        drain("random_drain", 50);

        // Reset mid-stream
        read_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'h30 + 8'(i));
        repeat (5) cycle();
        reset = 1'b1;
        exp_q.delete();
        @(negedge clock);
        chk("midreset_read_enable", {31'd0, fifo_read_enable}, 32'd0);
        cycle();
        @(negedge clock);
        chk("midreset_read_valid", {31'd0, read_valid}, 32'd0);
        cycle();
        reset = 1'b0;
        read_ready = 1'b1;
        cycle();
        push(8'h5A);
        drain("midreset_drain", 20);
        chk("midreset_idle", {31'd0, idle}, 32'd1);

        // Empty boundary: upstream toggles between one word and empty
        read_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push(8'h80 + 8'(i));
            cycle();
        end
        drain("toggle_drain", 20);
        chk("final_idle", {31'd0, idle}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
